// File: rtl/osd_pkg.sv
// rtl/osd_pkg.sv - shared types, alpha constants, colour codes and blend helper for the logo overlay
package osd_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        FADE = 2'd1,
        SHOW = 2'd2
    } osd_state_t;

    localparam int ALPHA_W   = 9;
    localparam int ALPHA_MAX = 256;

    localparam logic [2:0] COLOR_OFF   = 3'd0;
    localparam logic [2:0] COLOR_RED   = 3'd1;
    localparam logic [2:0] COLOR_GREEN = 3'd2;
    localparam logic [2:0] COLOR_BLUE  = 3'd3;
    localparam logic [2:0] COLOR_BLACK = 3'd4;

    // Truncating blend of one 8-bit channel; alpha 256 returns logo, 0 returns video.
    function automatic logic [7:0] blend_ch(
        input logic [7:0]         logo,
        input logic [7:0]         vid,
        input logic [ALPHA_W-1:0] alpha
    );
        logic [9:0]  inv;
        logic [16:0] acc;
        inv = 10'd256 - {1'b0, alpha};
        acc = 17'(logo) * 17'(alpha) + 17'(vid) * 17'(inv);
        return 8'(acc >> 8);
    endfunction

endpackage

// File: rtl/osd_delay_line.sv
// rtl/osd_delay_line.sv - WIDTH x DEPTH shift register with synchronous active-low clear
module osd_delay_line #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/logo_overlay_mixer.sv
// rtl/logo_overlay_mixer.sv - windowed logo alpha blend with per-frame fade-in; optional LOGO_CHROMA_KEY_EN
module logo_overlay_mixer
    import osd_pkg::*;
#(
    parameter int                DATA_W    = 24,
    parameter int                LOGO_X0   = 0,
    parameter int                LOGO_Y0   = 0,
    parameter int                LOGO_W    = 50,
    parameter int                LOGO_H    = 50,
    parameter int                LAT       = 2,
    parameter int                FADE_STEP = 32,
    parameter logic [DATA_W-1:0] KEY_COLOR = 24'h000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vid_de_i,
    input  logic              vid_hs_i,
    input  logic              vid_vs_i,
    input  logic [DATA_W-1:0] vid_data_i,
    input  logic [11:0]       pixel_x,
    input  logic [11:0]       pixel_y,
    input  logic [DATA_W-1:0] logo_data_i,
    input  logic [2:0]        color_select,
    output logic              vid_de_o,
    output logic              vid_hs_o,
    output logic              vid_vs_o,
    output logic [DATA_W-1:0] vid_data_o,
    output logic              fade_busy_o
);

    localparam int                 BUNDLE_W   = DATA_W + 4;
    localparam int                 STEP_CLAMP = (FADE_STEP > ALPHA_MAX) ? ALPHA_MAX : FADE_STEP;
    localparam logic [ALPHA_W-1:0] STEP_A     = ALPHA_W'(STEP_CLAMP);
    localparam logic [ALPHA_W-1:0] ALPHA_FULL = ALPHA_W'(ALPHA_MAX);

`ifdef LOGO_CHROMA_KEY_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    // A borrow on the subtraction lands far above the width, so one compare covers both bounds.
    logic [12:0] x_rel;
    logic [12:0] y_rel;
    logic        in_win;

    assign x_rel  = {1'b0, pixel_x} - 13'(LOGO_X0);
    assign y_rel  = {1'b0, pixel_y} - 13'(LOGO_Y0);
    assign in_win = vid_de_i && (x_rel < 13'(LOGO_W)) && (y_rel < 13'(LOGO_H));

    logic [BUNDLE_W-1:0] d_bundle;
    logic                d_vs;
    logic                d_hs;
    logic                d_de;
    logic                d_win;
    logic [DATA_W-1:0]   d_vid;

    osd_delay_line #(
        .WIDTH (BUNDLE_W),
        .DEPTH (LAT)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({vid_vs_i, vid_hs_i, vid_de_i, in_win, vid_data_i}),
        .dout  (d_bundle)
    );

    assign {d_vs, d_hs, d_de, d_win, d_vid} = d_bundle;

    logic vs_q;
    logic fs;

    assign fs = vid_vs_i && !vs_q;

    osd_state_t         state;
    osd_state_t         state_n;
    logic [ALPHA_W-1:0] alpha;
    logic [ALPHA_W-1:0] alpha_n;
    logic [2:0]         sel_last;
    logic [2:0]         sel_last_n;
    logic [ALPHA_W:0]   alpha_sum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_q     <= 1'b0;
            state    <= OFF;
            alpha    <= '0;
            sel_last <= COLOR_OFF;
        end else begin
            vs_q     <= vid_vs_i;
            state    <= state_n;
            alpha    <= alpha_n;
            sel_last <= sel_last_n;
        end
    end

    // Only the select seen on the frame-start cycle matters, so alpha is constant across a frame.
    always_comb begin
        state_n    = state;
        alpha_n    = alpha;
        sel_last_n = sel_last;
        alpha_sum  = {1'b0, alpha} + {1'b0, STEP_A};
        if (fs) begin
            if (color_select == COLOR_OFF) begin
                state_n    = OFF;
                alpha_n    = '0;
                sel_last_n = COLOR_OFF;
            end else if (color_select != sel_last) begin
                state_n    = FADE;
                alpha_n    = STEP_A;
                sel_last_n = color_select;
            end else if (state == FADE) begin
                if (alpha_sum >= (ALPHA_W+1)'(ALPHA_MAX)) begin
                    alpha_n = ALPHA_FULL;
                    state_n = SHOW;
                end else begin
                    alpha_n = alpha_sum[ALPHA_W-1:0];
                end
            end
        end
    end

    logic [DATA_W-1:0] blended;
    logic              key_hit;
    logic              pass;

    assign blended = {blend_ch(logo_data_i[23:16], d_vid[23:16], alpha),
                      blend_ch(logo_data_i[15:8],  d_vid[15:8],  alpha),
                      blend_ch(logo_data_i[7:0],   d_vid[7:0],   alpha)};
    assign key_hit = KEY_EN && (logo_data_i == KEY_COLOR);
    assign pass    = !d_win || !d_de || (state == OFF) || key_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vid_de_o   <= 1'b0;
            vid_hs_o   <= 1'b0;
            vid_vs_o   <= 1'b0;
            vid_data_o <= '0;
        end else begin
            vid_de_o   <= d_de;
            vid_hs_o   <= d_hs;
            vid_vs_o   <= d_vs;
            vid_data_o <= pass ? d_vid : blended;
        end
    end

    assign fade_busy_o = (state == FADE);

endmodule

// File: tb/tb_logo_overlay_mixer.sv
// tb/tb_logo_overlay_mixer.sv - frame-table driven scoreboard bench for logo_overlay_mixer
module tb_logo_overlay_mixer;

    localparam int H_ACT = 60;
    localparam int H_TOT = 64;
    localparam int V_BLK = 3;
    localparam int V_TOT = 55;
    localparam int LAT   = 2;
    localparam int NFRM  = 14;

`ifdef LOGO_CHROMA_KEY_EN
    localparam logic [23:0] KEY_EXP = 24'h123456;
`else
    localparam logic [23:0] KEY_EXP = 24'h000000;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vid_de_i, vid_hs_i, vid_vs_i;
    logic [23:0] vid_data_i;
    logic [11:0] pixel_x, pixel_y;
    logic [23:0] logo_data_i;
    logic [2:0]  color_select;
    logic        vid_de_o, vid_hs_o, vid_vs_o;
    logic [23:0] vid_data_o;
    logic        fade_busy_o;

    always #5 clk = ~clk;

    logo_overlay_mixer #(
        .FADE_STEP (64)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vid_de_i     (vid_de_i),
        .vid_hs_i     (vid_hs_i),
        .vid_vs_i     (vid_vs_i),
        .vid_data_i   (vid_data_i),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .logo_data_i  (logo_data_i),
        .color_select (color_select),
        .vid_de_o     (vid_de_o),
        .vid_hs_o     (vid_hs_o),
        .vid_vs_o     (vid_vs_o),
        .vid_data_o   (vid_data_o),
        .fade_busy_o  (fade_busy_o)
    );

    typedef struct {
        logic [2:0]  sel;
        logic [23:0] logo;
        logic [23:0] video;
        logic        ramp;
        logic [23:0] exp_win;
        logic        exp_busy;
        int          rst_row;
        logic        mid_en;
        logic [2:0]  mid_sel;
    } frame_vec_t;

    typedef struct {
        int          due;
        logic [26:0] exp;
    } sb_t;

    frame_vec_t  vecs [NFRM];
    sb_t         sbq [$];
    int          cyc    = 0;
    int          n_vec  = 0;
    int          n_bad  = 0;
    logic [23:0] logo_d1 = '0;
    logic [23:0] logo_d2 = '0;
    sb_t         mon_e;
    logic [26:0] mon_got;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            mon_e   = sbq.pop_front();
            mon_got = {vid_vs_o, vid_hs_o, vid_de_o, vid_data_o};
            n_vec++;
            if (mon_e.due != cyc || mon_got !== mon_e.exp) begin
                n_bad++;
                $display("FAIL out_bundle cyc=%0d due=%0d got=%h exp=%h", cyc, mon_e.due, mon_got, mon_e.exp);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic frame_vec_t mk(input logic [2:0] sel, input logic [23:0] logo, input logic [23:0] video,
                                      input logic ramp, input logic [23:0] exp_win, input logic exp_busy,
                                      input int rst_row, input logic mid_en, input logic [2:0] mid_sel);
        frame_vec_t v;
        v.sel = sel; v.logo = logo; v.video = video; v.ramp = ramp; v.exp_win = exp_win;
        v.exp_busy = exp_busy; v.rst_row = rst_row; v.mid_en = mid_en; v.mid_sel = mid_sel;
        return v;
    endfunction

    // One pixel clock: drive inputs, feed the logo through a LAT-deep pipe, queue the expected output.
    task automatic step(input logic rst, input logic de, input logic hs, input logic vs,
                        input logic [11:0] x, input logic [11:0] y, input logic [23:0] vid,
                        input logic [23:0] logo, input logic [2:0] sel, input logic [23:0] exp_data,
                        input logic push);
        @(posedge clk);
        #1;
        rst_n        = rst;
        vid_de_i     = de;
        vid_hs_i     = hs;
        vid_vs_i     = vs;
        pixel_x      = x;
        pixel_y      = y;
        vid_data_i   = vid;
        color_select = sel;
        logo_data_i  = logo_d2;
        logo_d2      = logo_d1;
        logo_d1      = logo;
        if (push) sbq.push_back('{due: cyc + LAT + 1, exp: {vs, hs, de, exp_data}});
    endtask

    task automatic run_frame(input frame_vec_t v, input int idx);
        logic        de, hs, vs, in_win, after_rst, rst_now, chk_rst;
        logic [11:0] x, y;
        logic [23:0] vid, exp_d;
        logic [2:0]  sel;
        after_rst = 1'b0;
        chk_rst   = 1'b0;
        sel       = color_select;
        for (int row = 0; row < V_TOT; row++) begin
            for (int col = 0; col < H_TOT; col++) begin
                x  = 12'(col);
                y  = 12'(row - V_BLK);
                de = (row >= V_BLK) && (col < H_ACT);
                hs = (col >= H_ACT);
                vs = (row == 0);
                if (row == 0 && col == 0) sel = v.sel;
                if (v.mid_en && row == V_BLK + 25 && col == 0) sel = v.mid_sel;
                vid     = v.ramp ? {x[7:0], y[7:0], x[7:0] ^ y[7:0]} : v.video;
                in_win  = de && (col < 50) && (row - V_BLK < 50);
                exp_d   = (in_win && !v.ramp && !after_rst) ? v.exp_win : vid;
                rst_now = (v.rst_row != 0) && (row == v.rst_row) && (col == 10);
                if (rst_now) begin
                    step(1'b0, de, hs, vs, x, y, vid, v.logo, sel, exp_d, 1'b0);
                    while (sbq.size() > 0 && sbq[$].due >= cyc + 1) void'(sbq.pop_back());
                    for (int k = 1; k <= LAT + 1; k++) sbq.push_back('{due: cyc + k, exp: 27'h0});
                    after_rst = 1'b1;
                    chk_rst   = 1'b1;
                end else begin
                    step(1'b1, de, hs, vs, x, y, vid, v.logo, sel, exp_d, 1'b1);
                    if (chk_rst) begin
                        check($sformatf("busy_after_reset f%0d", idx), {31'b0, fade_busy_o}, 32'h0);
                        chk_rst = 1'b0;
                    end
                end
                if (row == V_TOT - 1 && col == 0)
                    check($sformatf("fade_busy f%0d", idx), {31'b0, fade_busy_o}, {31'b0, v.exp_busy});
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        // FADE_STEP=64: alpha 64/128/192/256 gives 3F/7F/BF/FF of a full-scale logo channel over black.
        vecs[0]  = mk(3'd0, 24'hFF0000, 24'h000000, 1'b1, 24'h000000, 1'b0, 0,  1'b0, 3'd0);
        vecs[1]  = mk(3'd1, 24'hFF0000, 24'h000000, 1'b0, 24'h3F0000, 1'b1, 0,  1'b0, 3'd0);
        vecs[2]  = mk(3'd1, 24'hFF0000, 24'h000000, 1'b0, 24'h7F0000, 1'b1, 0,  1'b0, 3'd0);
        vecs[3]  = mk(3'd1, 24'hFF0000, 24'h000000, 1'b0, 24'hBF0000, 1'b1, 0,  1'b0, 3'd0);
        vecs[4]  = mk(3'd1, 24'hFF0000, 24'h000000, 1'b0, 24'hFF0000, 1'b0, 0,  1'b0, 3'd0);
        vecs[5]  = mk(3'd1, 24'hFF0000, 24'h123456, 1'b0, 24'hFF0000, 1'b0, 0,  1'b0, 3'd0);
        vecs[6]  = mk(3'd1, 24'h000000, 24'h123456, 1'b0, KEY_EXP,    1'b0, 0,  1'b0, 3'd0);
        vecs[7]  = mk(3'd1, 24'hFF0000, 24'h123456, 1'b0, 24'hFF0000, 1'b0, 23, 1'b0, 3'd0);
        vecs[8]  = mk(3'd1, 24'hFF0000, 24'h000000, 1'b0, 24'h3F0000, 1'b1, 0,  1'b0, 3'd0);
        vecs[9]  = mk(3'd1, 24'hFF0000, 24'h000000, 1'b0, 24'h7F0000, 1'b1, 0,  1'b1, 3'd2);
        vecs[10] = mk(3'd2, 24'h00FF00, 24'h000000, 1'b0, 24'h003F00, 1'b1, 0,  1'b0, 3'd0);
        vecs[11] = mk(3'd2, 24'h00FF00, 24'h000000, 1'b0, 24'h007F00, 1'b1, 0,  1'b1, 3'd4);
        vecs[12] = mk(3'd2, 24'h00FF00, 24'h000000, 1'b0, 24'h00BF00, 1'b1, 0,  1'b0, 3'd0);
        vecs[13] = mk(3'd0, 24'h00FF00, 24'h000000, 1'b1, 24'h000000, 1'b0, 0,  1'b0, 3'd0);

        rst_n = 1'b0; vid_de_i = 1'b0; vid_hs_i = 1'b0; vid_vs_i = 1'b0;
        vid_data_i = '0; pixel_x = '0; pixel_y = '0; logo_data_i = '0; color_select = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", {8'h0, vid_data_o}, 32'h0);
        check("reset_sync", {29'h0, vid_vs_o, vid_hs_o, vid_de_o}, 32'h0);
        check("reset_busy", {31'b0, fade_busy_o}, 32'h0);

        for (int f = 0; f < NFRM; f++) run_frame(vecs[f], f);

        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 12'h0, 24'h0, 24'h0, 3'd0, 24'h0, 1'b1);
        for (int k = 0; k < 20 && sbq.size() > 0; k++) @(negedge clk);
        #1;
        if (sbq.size() > 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d exp=0", sbq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
